bp_cfg_loader: RTL and testbench
================================

// Module: bp_cfg_loader
// PURPOSE
//  Config-link master that boots one tile after reset. It sequences the fixed cfg register writes
//  (freeze, reset, CCE ucode, start_pc, cce_mode, unfreeze) as addr/data packets into the cfg link
//  slave. Sits directly upstream of the cfg-link decode node. Ucode comes from an external sync ROM.
// PARAMETERS
//  ucode_words_p  256              number of CCE ucode words to write; legal range 0..4096
//  start_pc_p     64'h8000_0000    boot PC, split into lo/hi 32-bit writes
//  cce_mode_p     32'h0            value written to cce_mode register
//  clk_osc_p      32'h0            clk_osc value (used only with BP_CFG_LOADER_CLK_OSC_EN)
// PORTS
//  clk_i          in   1   clock
//  reset_i        in   1   synchronous, active-high reset
//  cfg_v_o        out  1   packet valid
//  cfg_addr_o     out  16  cfg register address
//  cfg_data_o     out  32  cfg write data
//  cfg_ready_i    in   1   slave accepts packet; transfer when cfg_v_o & cfg_ready_i
//  ucode_addr_o   out  12  ROM word address
//  ucode_data_i   in   32  ROM data, valid exactly 1 cycle after ucode_addr_o is presented
//  done_o         out  1   boot sequence complete; sticky until reset
// BEHAVIOUR
//  - Reset values: cfg_v_o=0, cfg_addr_o=0, cfg_data_o=0, ucode_addr_o=0, done_o=0; FSM=S_RESET; idx=0.
//  - Handshake:
//    - cfg_v_o never depends combinationally on cfg_ready_i.
//    - Once raised, cfg_v_o, cfg_addr_o and cfg_data_o hold stable until the transfer.
//    - Next packet may be driven the cycle after a transfer, so 1 write/cycle is sustainable
//      outside UCODE.
//  - FSM (advance on transfer unless noted), packet = addr/data:
//    - S_RESET -> S_FREEZE unconditionally, 1 cycle after reset_i drops.
//    - S_FREEZE     0x0002/1 -> S_RST_ON
//    - S_RST_ON     0x0001/1 -> S_RST_OFF
//    - S_RST_OFF    0x0001/0 -> S_UC_RD, or S_PC_LO if ucode_words_p==0
//    - S_UC_RD: no packet. Present ucode_addr_o=idx for 1 cycle -> S_UC_WR.
//    - S_UC_WR      (0x8000+idx)/ucode_data_i, captured into a holding reg the cycle after S_UC_RD.
//      On transfer: idx++. If idx==ucode_words_p-1 -> S_PC_LO, else -> S_UC_RD.
//    - S_PC_LO      0x0040/start_pc_p[31:0] -> S_PC_HI
//    - S_PC_HI      0x0041/start_pc_p[63:32] -> S_MODE
//    - S_MODE       0x0060/cce_mode_p -> S_UNFREEZE
//    - S_UNFREEZE   0x0002/0 -> S_DONE
//    - S_DONE: cfg_v_o=0; done_o=1 from the cycle after the unfreeze transfer; terminal.
//  - Ucode timing: 2 cycles/word minimum (read + write); stalls on cfg_ready_i extend S_UC_WR only.
//  - Widths: idx is 13 bits so 4096 does not wrap.
//    - cfg_addr_o = 16'h8000 | idx[11:0].
//    - ucode_addr_o = idx[11:0].
//  - Reset mid-operation (including mid-handshake with cfg_v_o=1):
//    - Next cycle cfg_v_o=0 and FSM=S_RESET; the whole sequence replays.
//    - Slave must tolerate the abandoned packet.
//  - Any transfer after S_DONE is impossible; cfg_ready_i is ignored in S_DONE and S_UC_RD.
// CONFIGURATION
//  - BP_CFG_LOADER_CLK_OSC_EN defined:
//    - Extra state S_CLK_OSC between S_RESET and S_FREEZE writes 0x0000/clk_osc_p.
//    - Total packets = 8 + ucode_words_p.
//  - Undefined: S_CLK_OSC is absent; S_RESET -> S_FREEZE; total packets = 7 + ucode_words_p;
//    clk_osc_p is unused.
// STRUCTURE
//  - Shared package (with the cfg-link address constants):
//    - typedef enum bp_cfg_loader_state_e.
//    - typedef struct bp_cfg_link_pkt_s {addr[15:0], data[31:0]}.
//  - Address constants come from the existing cfg-link register localparams; no literals in the RTL.
//  - One sub-module: bsg_counter_clear_up for idx (clear on reset, up on ucode transfer).
//  - Holding reg for ROM data: plain dff_en.
// TESTING
//  1. ucode_words_p=4, ready tied 1 -> exactly 11 packets in order:
//     0002/1, 0001/1, 0001/0, 8000..8003/ROM[0..3], 0040, 0041, 0060, 0002/0;
//     done_o rises 1 cycle after the last packet.
//  2. Random cfg_ready_i backpressure (50%) -> same packet sequence.
//     Addr/data never change while cfg_v_o=1 && !cfg_ready_i.
//  3. ucode_words_p=0 -> S_RST_OFF goes directly to 0040;
//     no ucode_addr_o activity beyond the reset value; 7 packets.
//  4. Reset asserted during S_UC_WR idx=2 with ready=0 -> next cycle cfg_v_o=0, done_o=0;
//     sequence restarts with 0002/1 and ucode idx 0.
//  5. start_pc_p=64'h1234_5678_9ABC_DEF0 -> 0040/9ABCDEF0 then 0041/12345678.
//  6. With BP_CFG_LOADER_CLK_OSC_EN, clk_osc_p=5 -> first packet 0000/5; total 8+N packets.

Source files
------------

// File: rtl/bp_cfg_loader_pkg.sv
// Shared types and cfg-link register addresses for the tile boot loader.
package bp_cfg_loader_pkg;

    // cfg-link register map, shared with the cfg-link decode node
    localparam logic [15:0] CfgAddrClkOsc    = 16'h0000;
    localparam logic [15:0] CfgAddrReset     = 16'h0001;
    localparam logic [15:0] CfgAddrFreeze    = 16'h0002;
    localparam logic [15:0] CfgAddrStartPcLo = 16'h0040;
    localparam logic [15:0] CfgAddrStartPcHi = 16'h0041;
    localparam logic [15:0] CfgAddrCceMode   = 16'h0060;
    localparam logic [15:0] CfgAddrUcodeBase = 16'h8000;

    typedef enum logic [3:0] {
        S_RESET,
        S_CLK_OSC,
        S_FREEZE,
        S_RST_ON,
        S_RST_OFF,
        S_UC_RD,
        S_UC_WR,
        S_PC_LO,
        S_PC_HI,
        S_MODE,
        S_UNFREEZE,
        S_DONE
    } bp_cfg_loader_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } bp_cfg_link_pkt_s;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous reset and clear; clear wins over up.
module bsg_counter_clear_up #(
    parameter int unsigned width_p = 13
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] r_count;

    // count register
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            r_count <= '0;
        end else if (up_i) begin
            r_count <= r_count + width_p'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/bp_cfg_loader.sv
// Config-link master that boots one tile: freeze, reset pulse, CCE ucode, start PC,
// CCE mode, unfreeze. Ucode words are fetched from an external 1-cycle sync ROM.
// Optional feature: define BP_CFG_LOADER_CLK_OSC_EN to write clk_osc_p first.
module bp_cfg_loader
    import bp_cfg_loader_pkg::*;
#(
    parameter int unsigned  ucode_words_p = 256,
    parameter logic [63:0]  start_pc_p    = 64'h8000_0000,
    parameter logic [31:0]  cce_mode_p    = 32'h0,
    parameter logic [31:0]  clk_osc_p     = 32'h0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        cfg_v_o,
    output logic [15:0] cfg_addr_o,
    output logic [31:0] cfg_data_o,
    input  logic        cfg_ready_i,
    output logic [11:0] ucode_addr_o,
    input  logic [31:0] ucode_data_i,
    output logic        done_o
);

    // Underflow for ucode_words_p==0 is harmless: S_UC_WR is never entered then.
    localparam logic [12:0] LastIdx = 13'(ucode_words_p - 1);

    bp_cfg_loader_state_e r_state, w_state_d;
    bp_cfg_link_pkt_s     w_pkt;
    logic                 w_v;
    logic                 w_idx_up;
    logic [12:0]          w_idx;
    logic                 r_uc_fresh;
    logic [31:0]          r_uc_hold;
    logic [31:0]          w_uc_data;

    bsg_counter_clear_up #(
        .width_p (13)
    ) u_idx (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (r_state == S_RESET),
        .up_i    (w_idx_up),
        .count_o (w_idx)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ROM data is live only in the first S_UC_WR cycle; hold it for any stall after that
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_uc_fresh <= 1'b0;
            r_uc_hold  <= '0;
        end else begin
            r_uc_fresh <= (r_state == S_UC_RD);
            if (r_uc_fresh) begin
                r_uc_hold <= ucode_data_i;
            end
        end
    end

    assign w_uc_data = r_uc_fresh ? ucode_data_i : r_uc_hold;

    // Next state and packet; valid/addr/data depend on state only, never on ready
    always_comb begin
        w_state_d = r_state;
        w_pkt     = '0;
        w_v       = 1'b0;
        w_idx_up  = 1'b0;
        unique case (r_state)
            S_RESET: begin
`ifdef BP_CFG_LOADER_CLK_OSC_EN
                w_state_d = S_CLK_OSC;
`else
                w_state_d = S_FREEZE;
`endif
            end
            S_CLK_OSC: begin
                w_v   = 1'b1;
                w_pkt = '{addr: CfgAddrClkOsc, data: clk_osc_p};
                if (cfg_ready_i) w_state_d = S_FREEZE;
            end
            S_FREEZE: begin
                w_v   = 1'b1;
                w_pkt = '{addr: CfgAddrFreeze, data: 32'd1};
                if (cfg_ready_i) w_state_d = S_RST_ON;
            end
            S_RST_ON: begin
                w_v   = 1'b1;
                w_pkt = '{addr: CfgAddrReset, data: 32'd1};
                if (cfg_ready_i) w_state_d = S_RST_OFF;
            end
            S_RST_OFF: begin
                w_v   = 1'b1;
                w_pkt = '{addr: CfgAddrReset, data: 32'd0};
                if (cfg_ready_i) w_state_d = (ucode_words_p == 0) ? S_PC_LO : S_UC_RD;
            end
            S_UC_RD: begin
                w_state_d = S_UC_WR;
            end
            S_UC_WR: begin
                w_v   = 1'b1;
                w_pkt = '{addr: CfgAddrUcodeBase | {4'b0, w_idx[11:0]}, data: w_uc_data};
                if (cfg_ready_i) begin
                    w_idx_up  = 1'b1;
                    w_state_d = (w_idx == LastIdx) ? S_PC_LO : S_UC_RD;
                end
            end
            S_PC_LO: begin
                w_v   = 1'b1;
                w_pkt = '{addr: CfgAddrStartPcLo, data: start_pc_p[31:0]};
                if (cfg_ready_i) w_state_d = S_PC_HI;
            end
            S_PC_HI: begin
                w_v   = 1'b1;
                w_pkt = '{addr: CfgAddrStartPcHi, data: start_pc_p[63:32]};
                if (cfg_ready_i) w_state_d = S_MODE;
            end
            S_MODE: begin
                w_v   = 1'b1;
                w_pkt = '{addr: CfgAddrCceMode, data: cce_mode_p};
                if (cfg_ready_i) w_state_d = S_UNFREEZE;
            end
            S_UNFREEZE: begin
                w_v   = 1'b1;
                w_pkt = '{addr: CfgAddrFreeze, data: 32'd0};
                if (cfg_ready_i) w_state_d = S_DONE;
            end
            S_DONE: begin
                w_state_d = S_DONE;
            end
            default: begin
                w_state_d = S_RESET;
            end
        endcase
    end

    assign cfg_v_o      = w_v;
    assign cfg_addr_o   = w_pkt.addr;
    assign cfg_data_o   = w_pkt.data;
    assign ucode_addr_o = w_idx[11:0];
    assign done_o       = (r_state == S_DONE);

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Bench for bp_cfg_loader: instance 0 boots 4 ucode words with a custom PC/mode,
// instance 1 boots with no ucode. A reference model lists the expected packets.
module tb_bp_cfg_loader;

`ifdef BP_CFG_LOADER_CLK_OSC_EN
    localparam int Ofs = 1;
`else
    localparam int Ofs = 0;
`endif

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        rdy   [2];
    logic        cfg_v [2];
    logic [15:0] cfg_addr [2];
    logic [31:0] cfg_data [2];
    logic [11:0] uaddr [2];
    logic [31:0] rom_q [2];
    logic        done [2];

    int n_chk  = 0;
    int n_fail = 0;

    logic [47:0] log0 [$];
    logic [47:0] log1 [$];

    always #5 clk = ~clk;

    bp_cfg_loader #(
        .ucode_words_p (4),
        .start_pc_p    (64'h1234_5678_9ABC_DEF0),
        .cce_mode_p    (32'h0000_00A5),
        .clk_osc_p     (32'h0000_0005)
    ) dut_a (
        .clk_i        (clk),
        .reset_i      (rst[0]),
        .cfg_v_o      (cfg_v[0]),
        .cfg_addr_o   (cfg_addr[0]),
        .cfg_data_o   (cfg_data[0]),
        .cfg_ready_i  (rdy[0]),
        .ucode_addr_o (uaddr[0]),
        .ucode_data_i (rom_q[0]),
        .done_o       (done[0])
    );

    bp_cfg_loader #(
        .ucode_words_p (0),
        .start_pc_p    (64'h8000_0000),
        .cce_mode_p    (32'h0),
        .clk_osc_p     (32'h0000_0005)
    ) dut_b (
        .clk_i        (clk),
        .reset_i      (rst[1]),
        .cfg_v_o      (cfg_v[1]),
        .cfg_addr_o   (cfg_addr[1]),
        .cfg_data_o   (cfg_data[1]),
        .cfg_ready_i  (rdy[1]),
        .ucode_addr_o (uaddr[1]),
        .ucode_data_i (rom_q[1]),
        .done_o       (done[1])
    );

    function automatic logic [31:0] rom_word(int inst, logic [11:0] a);
        return 32'hA5A5_0000 + 32'(a) * 32'h0101 + 32'(inst) * 32'h0010_0000;
    endfunction

    // Sync ROM: data for the address seen at an edge appears after that edge
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) rom_q[i] <= rom_word(i, uaddr[i]);
    end

    // Expected k-th packet {addr,data} of a boot sequence
    function automatic logic [47:0] exp_pkt(int inst, int k);
        int          n;
        int          j;
        logic [63:0] pc;
        logic [31:0] mode;
        n    = (inst == 0) ? 4 : 0;
        pc   = (inst == 0) ? 64'h1234_5678_9ABC_DEF0 : 64'h8000_0000;
        mode = (inst == 0) ? 32'h0000_00A5 : 32'h0;
        j    = k;
`ifdef BP_CFG_LOADER_CLK_OSC_EN
        if (j == 0) return {16'h0000, 32'h5};
        j = j - 1;
`endif
        if (j == 0) return {16'h0002, 32'd1};
        if (j == 1) return {16'h0001, 32'd1};
        if (j == 2) return {16'h0001, 32'd0};
        if (j < 3 + n) return {16'h8000 + 16'(j - 3), rom_word(inst, 12'(j - 3))};
        j = j - n;
        if (j == 3) return {16'h0040, pc[31:0]};
        if (j == 4) return {16'h0041, pc[63:32]};
        if (j == 5) return {16'h0060, mode};
        return {16'h0002, 32'd0};
    endfunction

    function automatic int total_pkts(int inst);
        return 7 + Ofs + ((inst == 0) ? 4 : 0);
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both instances against the reference sequence
    int          ptr [2];
    bit          prev_stall [2];
    logic [47:0] prev_pkt [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                ptr[i]        = 0;
                prev_stall[i] = 1'b0;
            end else begin
                automatic bit          fin = (ptr[i] >= total_pkts(i));
                automatic logic [47:0] pkt = {cfg_addr[i], cfg_data[i]};
                chk(done[i] == fin, "done_o", 64'(done[i]), 64'(fin));
                if (fin) chk(!cfg_v[i], "idle_after_done", 64'(cfg_v[i]), 64'(0));
                if (prev_stall[i])
                    chk(cfg_v[i] && pkt == prev_pkt[i], "hold_under_stall",
                        {15'd0, cfg_v[i], pkt}, {16'd1, prev_pkt[i]});
                if (i == 1) chk(uaddr[1] == 12'd0, "no_ucode_addr", 64'(uaddr[1]), 64'(0));
                if (cfg_v[i] && rdy[i]) begin
                    if (fin) begin
                        chk(1'b0, "extra_packet", 64'(pkt), 64'(0));
                    end else begin
                        chk(pkt == exp_pkt(i, ptr[i]), "packet", 64'(pkt),
                            64'(exp_pkt(i, ptr[i])));
                    end
                    if (i == 0) log0.push_back(pkt);
                    else log1.push_back(pkt);
                    ptr[i]++;
                end
                prev_stall[i] = cfg_v[i] && !rdy[i];
                prev_pkt[i]   = pkt;
            end
        end
    end

    task automatic wait_done(input int inst, input int budget, input bit rand_rdy);
        int c;
        c = 0;
        while (!done[inst] && c < budget) begin
            @(posedge clk);
            #1;
            if (rand_rdy) rdy[inst] = 1'($urandom_range(0, 1));
            c++;
        end
        chk(done[inst], "done_within_budget", 64'(done[inst]), 64'(1));
    endtask

    task automatic do_reset(input int inst);
        rst[inst] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (inst == 0) log0.delete();
        else log1.delete();
    endtask

    initial begin
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;

        // Reset values
        do_reset(0);
        chk(!cfg_v[0], "rst_cfg_v", 64'(cfg_v[0]), 64'(0));
        chk(cfg_addr[0] == 16'h0, "rst_cfg_addr", 64'(cfg_addr[0]), 64'(0));
        chk(cfg_data[0] == 32'h0, "rst_cfg_data", 64'(cfg_data[0]), 64'(0));
        chk(uaddr[0] == 12'h0, "rst_ucode_addr", 64'(uaddr[0]), 64'(0));
        chk(!done[0], "rst_done", 64'(done[0]), 64'(0));

        // 4 ucode words, ready tied high
        rst[0] = 1'b0;
        wait_done(0, 200, 1'b0);
        chk(log0.size() == 11 + Ofs, "pkt_count_n4", 64'(log0.size()), 64'(11 + Ofs));
`ifdef BP_CFG_LOADER_CLK_OSC_EN
        chk(log0[0] == {16'h0000, 32'h5}, "clk_osc_first", 64'(log0[0]), 64'({16'h0, 32'h5}));
`endif
        chk(log0[Ofs] == {16'h0002, 32'h1}, "freeze", 64'(log0[Ofs]), 64'({16'h2, 32'h1}));
        chk(log0[Ofs + 3] == {16'h8000, 32'hA5A5_0000}, "ucode0", 64'(log0[Ofs + 3]),
            64'({16'h8000, 32'hA5A5_0000}));
        chk(log0[Ofs + 6] == {16'h8003, 32'hA5A5_0303}, "ucode3", 64'(log0[Ofs + 6]),
            64'({16'h8003, 32'hA5A5_0303}));
        chk(log0[Ofs + 7] == {16'h0040, 32'h9ABC_DEF0}, "pc_lo", 64'(log0[Ofs + 7]),
            64'({16'h0040, 32'h9ABC_DEF0}));
        chk(log0[Ofs + 8] == {16'h0041, 32'h1234_5678}, "pc_hi", 64'(log0[Ofs + 8]),
            64'({16'h0041, 32'h1234_5678}));
        chk(log0[Ofs + 9] == {16'h0060, 32'hA5}, "cce_mode", 64'(log0[Ofs + 9]),
            64'({16'h0060, 32'hA5}));
        chk(log0[Ofs + 10] == {16'h0002, 32'h0}, "unfreeze", 64'(log0[Ofs + 10]),
            64'({16'h0002, 32'h0}));

        // Random backpressure
        do_reset(0);
        rst[0] = 1'b0;
        wait_done(0, 600, 1'b1);
        chk(log0.size() == 11 + Ofs, "pkt_count_bp", 64'(log0.size()), 64'(11 + Ofs));

        // Zero ucode words
        rst[1] = 1'b0;
        wait_done(1, 200, 1'b0);
        chk(log1.size() == 7 + Ofs, "pkt_count_n0", 64'(log1.size()), 64'(7 + Ofs));
        chk(log1[Ofs + 3] == {16'h0040, 32'h8000_0000}, "n0_rst_off_to_pc", 64'(log1[Ofs + 3]),
            64'({16'h0040, 32'h8000_0000}));

        // Reset while stalled on ucode word 2
        rdy[0] = 1'b1;
        do_reset(0);
        rst[0] = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (cfg_v[0] && cfg_addr[0] == 16'h8002) break;
        end
        chk(cfg_v[0] && cfg_addr[0] == 16'h8002, "reach_ucode2", 64'(cfg_addr[0]), 64'(16'h8002));
        rdy[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        chk(!cfg_v[0], "midrst_cfg_v", 64'(cfg_v[0]), 64'(0));
        chk(!done[0], "midrst_done", 64'(done[0]), 64'(0));
        chk(uaddr[0] == 12'h0, "midrst_idx", 64'(uaddr[0]), 64'(0));
        log0.delete();
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rdy[0] = 1'b1;
        wait_done(0, 200, 1'b0);
        chk(log0.size() == 11 + Ofs, "pkt_count_replay", 64'(log0.size()), 64'(11 + Ofs));
        chk(log0[Ofs] == {16'h0002, 32'h1}, "replay_freeze", 64'(log0[Ofs]),
            64'({16'h2, 32'h1}));
        chk(log0[Ofs + 3] == {16'h8000, 32'hA5A5_0000}, "replay_ucode0", 64'(log0[Ofs + 3]),
            64'({16'h8000, 32'hA5A5_0000}));

        // done stays sticky and ready is ignored once finished
        repeat (5) @(posedge clk);
        #1;
        chk(done[0] && done[1], "done_sticky", {62'd0, done[1], done[0]}, 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
